pix_timing_gen: RTL
===================

# pix_timing_gen

Raster timing generator for the tetris VGA pipeline. It sits directly upstream of the tetris drawing stage and supplies the pixel coordinates and the hsync, vsync and data-enable strobes that the drawing stage consumes. It also produces line-start and frame-start strobes and, optionally, a free-running frame counter used for blink and animation effects. All outputs are registered and mutually aligned.

## Interface
- `PIX_WIDTH`, 12: width of `pix_x_o` and `pix_y_o`.
- `H_DISP`, 1280: active pixels per line.
- `H_FPORCH`, 48: horizontal front porch, in pixels.
- `H_SYNC`, 112: hsync width, in pixels.
- `H_BPORCH`, 248: horizontal back porch, in pixels.
- `V_DISP`, 1024: active lines per frame.
- `V_FPORCH`, 1: vertical front porch, in lines.
- `V_SYNC`, 3: vsync width, in lines.
- `V_BPORCH`, 38: vertical back porch, in lines.
- `HS_POL`, 0: active level of hsync.
- `VS_POL`, 0: active level of vsync.

- `clk_i`, in, 1: pixel clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `en_i`, in, 1: advance enable. When low, the counters and all outputs hold.
- `pix_hs_o`, out, 1: hsync, driven at level `HS_POL` while active.
- `pix_vs_o`, out, 1: vsync, driven at level `VS_POL` while active.
- `pix_de_o`, out, 1: high inside the visible area.
- `pix_x_o`, out, `PIX_WIDTH`: horizontal position, 0..H_TOTAL-1.
- `pix_y_o`, out, `PIX_WIDTH`: vertical position, 0..V_TOTAL-1.
- `line_start_o`, out, 1: one-cycle pulse when x=0.
- `frame_start_o`, out, 1: one-cycle pulse when x=0 and y=0.
- `frame_cnt_o`, out, 8: frame counter. Present only when `PIX_TIMING_FRAME_CNT_EN` is defined.

## Operation
- H_TOTAL = H_DISP+H_FPORCH+H_SYNC+H_BPORCH, which is 1688 at the defaults.
- V_TOTAL = V_DISP+V_FPORCH+V_SYNC+V_BPORCH, which is 1066 at the defaults.
- Elaboration fails with `$error` if H_TOTAL-1 or V_TOTAL-1 does not fit in `PIX_WIDTH` bits, or if any timing parameter is 0.
- Internal counters:
  - `h_cnt` counts 0..H_TOTAL-1. On a clock edge with `en_i`=1 it increments, and wraps to 0 after H_TOTAL-1.
  - `v_cnt` increments only when `h_cnt` wraps. It wraps to 0 after V_TOTAL-1, which ends the frame.
- Region order along each axis: active region, then front porch, then sync, then back porch.
- Output equations, all computed from the current counter state:
  - `de` = (h < H_DISP) && (v < V_DISP).
  - hsync is active for H_DISP+H_FPORCH ≤ h < H_DISP+H_FPORCH+H_SYNC, on every line including blanking lines.
  - vsync is active for V_DISP+V_FPORCH ≤ v < V_DISP+V_FPORCH+V_SYNC. It asserts and deasserts for whole lines, with transitions aligned to h=0.
  - x = h and y = v, unclamped. During blanking the coordinates run past the display size; downstream stages gate on `de`.
- All outputs are registered from the current counter state on the same enabled edge, so they stay mutually aligned.
- Reset values: counters 0; `pix_hs_o`=~HS_POL; `pix_vs_o`=~VS_POL; `pix_de_o`=0; x=y=0; both strobes 0; `frame_cnt_o`=0.
- Simultaneous events:
  - At the last pixel of a frame, `h_cnt` and `v_cnt` both wrap on the same edge.
  - The next output cycle asserts `line_start_o` and `frame_start_o` together.
- Behaviour while `en_i`=0:
  - The counters hold and every output register holds, including the strobes.
  - A strobe that is high while `en_i` is low stays high until the next enabled edge; downstream stages qualify strobes with `en_i`.
- Reset mid-frame: outputs take their reset values immediately and asynchronously. After release, scanning restarts from (0,0).

## Timing
- Latency is one cycle. The counter state (h,v) present before an enabled edge appears on the outputs after that edge.
- After reset release, the first enabled edge produces x=0, y=0, `de`=1, `line_start_o`=1, `frame_start_o`=1.
- With `en_i` held at 1 the outputs advance one pixel per cycle, and a frame lasts H_TOTAL×V_TOTAL cycles.
- Outputs have no combinational path from inputs; `rst_i` is the only asynchronous path.

## Configuration
- `PIX_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt_o` exists.
  - It increments by 1, modulo 256, on every edge that asserts `frame_start_o`, so the new value appears in the same cycle as the strobe.
- Not defined: the port and its register are absent and all other behaviour is unchanged.

## Test plan
Parameters for all scenarios: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), HS_POL=VS_POL=0, so one frame is 112 cycles.
- Reset: hold `rst_i`=1 -> hs=1, vs=1, de=0, x=y=0, strobes 0, frame_cnt=0.
- Release reset with `en_i`=1 -> first cycle x=0, y=0, de=1, both strobes 1. Each active line then shows de high for 8 cycles and low for 6, with hs=0 exactly at x=10..12.
- Vertical timing over a full frame -> vs=0 exactly for y=5..6 (28 cycles); de=0 for y≥4; `frame_start_o` pulses every 112 cycles.
- Drop `en_i` for 5 cycles while x=3, y=1 -> all outputs frozen at x=3; the first enabled edge after that gives x=4.
- With `PIX_TIMING_FRAME_CNT_EN` defined, run 256 frames -> frame_cnt steps 1..255 and then returns to 0, changing only on `frame_start_o` cycles.
- Assert `rst_i` asynchronously between edges at x=5, y=2 -> outputs reach reset values before the next edge; after release the scan resumes from (0,0) with `frame_start_o`=1.

Source files
------------

// File: rtl/pix_timing_gen.sv
// Raster timing generator: pixel coordinates, sync/data-enable and line/frame strobes.
// Optional 8-bit frame counter port is built when PIX_TIMING_FRAME_CNT_EN is defined.
module pix_timing_gen #(
    parameter int unsigned PIX_WIDTH = 12,
    parameter int unsigned H_DISP    = 1280,
    parameter int unsigned H_FPORCH  = 48,
    parameter int unsigned H_SYNC    = 112,
    parameter int unsigned H_BPORCH  = 248,
    parameter int unsigned V_DISP    = 1024,
    parameter int unsigned V_FPORCH  = 1,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BPORCH  = 38,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    output logic                 pix_hs_o,
    output logic                 pix_vs_o,
    output logic                 pix_de_o,
    output logic [PIX_WIDTH-1:0] pix_x_o,
    output logic [PIX_WIDTH-1:0] pix_y_o,
    output logic                 line_start_o,
    output logic                 frame_start_o
`ifdef PIX_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]           frame_cnt_o
`endif
);

    localparam int unsigned H_TOTAL      = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int unsigned V_TOTAL      = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;
    localparam int unsigned H_SYNC_START = H_DISP + H_FPORCH;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_DISP + V_FPORCH;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [PIX_WIDTH-1:0] H_LAST = PIX_WIDTH'(H_TOTAL - 32'd1);
    localparam logic [PIX_WIDTH-1:0] V_LAST = PIX_WIDTH'(V_TOTAL - 32'd1);
    localparam logic [PIX_WIDTH-1:0] ONE    = PIX_WIDTH'(32'd1);

    if (H_DISP == 32'd0 || H_FPORCH == 32'd0 || H_SYNC == 32'd0 || H_BPORCH == 32'd0 ||
        V_DISP == 32'd0 || V_FPORCH == 32'd0 || V_SYNC == 32'd0 || V_BPORCH == 32'd0) begin : g_zero_param
        $error("pix_timing_gen: every timing parameter must be non-zero");
    end

    if (((H_TOTAL - 32'd1) >> PIX_WIDTH) != 32'd0 ||
        ((V_TOTAL - 32'd1) >> PIX_WIDTH) != 32'd0) begin : g_width_check
        $error("pix_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in PIX_WIDTH bits");
    end

    logic [PIX_WIDTH-1:0] h_cnt_r;
    logic [PIX_WIDTH-1:0] v_cnt_r;
    logic [PIX_WIDTH-1:0] h_nxt_s;
    logic [PIX_WIDTH-1:0] v_nxt_s;
    logic                 h_last_s;
    logic                 v_last_s;
    logic                 de_s;
    logic                 hs_act_s;
    logic                 vs_act_s;
    logic                 line_start_s;
    logic                 frame_start_s;

    // Next counter state and decoded outputs for the current (h,v) position.
    always_comb begin
        h_last_s      = (h_cnt_r == H_LAST);
        v_last_s      = (v_cnt_r == V_LAST);
        h_nxt_s       = h_cnt_r;
        v_nxt_s       = v_cnt_r;
        if (h_last_s) begin
            h_nxt_s = '0;
            if (v_last_s) begin
                v_nxt_s = '0;
            end else begin
                v_nxt_s = v_cnt_r + ONE;
            end
        end else begin
            h_nxt_s = h_cnt_r + ONE;
        end
        de_s          = (h_cnt_r < PIX_WIDTH'(H_DISP)) && (v_cnt_r < PIX_WIDTH'(V_DISP));
        hs_act_s      = (h_cnt_r >= PIX_WIDTH'(H_SYNC_START)) && (h_cnt_r < PIX_WIDTH'(H_SYNC_END));
        vs_act_s      = (v_cnt_r >= PIX_WIDTH'(V_SYNC_START)) && (v_cnt_r < PIX_WIDTH'(V_SYNC_END));
        line_start_s  = (h_cnt_r == '0);
        frame_start_s = line_start_s && (v_cnt_r == '0);
    end

    // Counters and output registers; everything holds while en_i is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_r       <= '0;
            v_cnt_r       <= '0;
            pix_hs_o      <= ~HS_POL;
            pix_vs_o      <= ~VS_POL;
            pix_de_o      <= 1'b0;
            pix_x_o       <= '0;
            pix_y_o       <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else if (en_i) begin
            h_cnt_r       <= h_nxt_s;
            v_cnt_r       <= v_nxt_s;
            pix_hs_o      <= hs_act_s ? HS_POL : ~HS_POL;
            pix_vs_o      <= vs_act_s ? VS_POL : ~VS_POL;
            pix_de_o      <= de_s;
            pix_x_o       <= h_cnt_r;
            pix_y_o       <= v_cnt_r;
            line_start_o  <= line_start_s;
            frame_start_o <= frame_start_s;
        end
    end

`ifdef PIX_TIMING_FRAME_CNT_EN
    // Frame counter steps on the same edge that raises frame_start_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_o <= 8'd0;
        end else if (en_i && frame_start_s) begin
            frame_cnt_o <= frame_cnt_o + 8'd1;
        end
    end
`endif

endmodule
